// File: rtl/obi_mem_bridge.sv
// OBI slave to single-port SRAM bridge with optional grant wait states.
// One-stage registered response path; counts granted transfers.
`timescale 1ns/1ps
module obi_mem_bridge #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 16384,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic [31:0]                  addr_i,
  input  logic                         we_i,
  input  logic [3:0]                   be_i,
  input  logic [31:0]                  wdata_i,
  output logic                         gnt_o,
  output logic                         rvalid_o,
  output logic [31:0]                  rdata_o,
  output logic                         err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i,
  output logic [31:0]                  xfer_cnt_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_gnt;
  logic        r_rvalid;
  logic        r_err;
  logic        r_rd;
  logic [31:0] r_xfer;

  logic [32:0] w_a;
  logic [32:0] w_lo;
  logic [32:0] w_hi;
  logic        w_in_range;
  logic [31:0] w_off;
  logic        w_unused;

  // 33-bit compare so a window touching 4 GiB never wraps.
  assign w_a        = {1'b0, addr_i};
  assign w_lo       = {1'b0, ADDR_BASE};
  assign w_hi       = w_lo + (33'(MEM_WORDS) << 2);
  assign w_in_range = (w_a >= w_lo) && (w_a < w_hi);
  assign w_off      = addr_i - ADDR_BASE;
  assign w_unused   = ^w_off;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            w_gnt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_gnt       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    if (rst_i) begin
      w_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= 1'b0;
      r_xfer   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & ~w_in_range;
      r_rd     <= w_gnt & w_in_range & ~we_i;
      if (w_gnt) begin
        r_xfer <= r_xfer + 32'd1;
      end
    end
  end

  assign gnt_o       = w_gnt;
  assign mem_req_o   = w_gnt & w_in_range;
  assign mem_addr_o  = w_off[AW+1:2];
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  // SRAM data arrives in the response cycle, so it is muxed, not stored.
  assign rvalid_o   = r_rvalid;
  assign rdata_o    = (r_rvalid & r_rd) ? mem_rdata_i : 32'd0;
  assign err_o      = r_rvalid & r_err;
  assign xfer_cnt_o = r_xfer;

endmodule

// File: tb/tb_obi_mem_bridge.sv
// Directed bench for obi_mem_bridge across four parameter sets.
// Shared clock/reset/address bus, one request line per instance.
`timescale 1ns/1ps
module tb_obi_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = 32'd0;
  logic        req0 = 1'b0, req3 = 1'b0, req4 = 1'b0, reqB = 1'b0;

  logic        gnt0, rv0, err0, mreq0, mwe0;
  logic [31:0] rd0, mwd0, xc0;
  logic [3:0]  mbe0;
  logic [13:0] maddr0;
  logic [31:0] mrd0 = 32'd0;

  logic        gnt3, rv3, err3, mreq3, mwe3;
  logic [31:0] rd3, mwd3, xc3;
  logic [3:0]  mbe3;
  logic [13:0] maddr3;
  logic [31:0] mrd3 = 32'd0;

  logic        gnt4, rv4, err4, mreq4, mwe4;
  logic [31:0] rd4, mwd4, xc4;
  logic [3:0]  mbe4;
  logic [13:0] maddr4;
  logic [31:0] mrd4;

  logic        gntB, rvB, errB, mreqB, mweB;
  logic [31:0] rdB, mwdB, xcB;
  logic [3:0]  mbeB;
  logic [3:0]  maddrB;
  logic [31:0] mrdB;

  int checks = 0;
  int failures = 0;

  assign mrd4 = 32'h5555_AAAA;
  assign mrdB = 32'hCAFE_F00D;

  always #5 clk = ~clk;

  obi_mem_bridge #(.WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rv0),
    .rdata_o(rd0), .err_o(err0), .mem_req_o(mreq0), .mem_we_o(mwe0),
    .mem_be_o(mbe0), .mem_addr_o(maddr0), .mem_wdata_o(mwd0),
    .mem_rdata_i(mrd0), .xfer_cnt_o(xc0));

  obi_mem_bridge #(.WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3),
    .rdata_o(rd3), .err_o(err3), .mem_req_o(mreq3), .mem_we_o(mwe3),
    .mem_be_o(mbe3), .mem_addr_o(maddr3), .mem_wdata_o(mwd3),
    .mem_rdata_i(mrd3), .xfer_cnt_o(xc3));

  obi_mem_bridge #(.WAIT_CYCLES(4)) u_w4 (
    .clk_i(clk), .rst_i(rst), .req_i(req4), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .gnt_o(gnt4), .rvalid_o(rv4),
    .rdata_o(rd4), .err_o(err4), .mem_req_o(mreq4), .mem_we_o(mwe4),
    .mem_be_o(mbe4), .mem_addr_o(maddr4), .mem_wdata_o(mwd4),
    .mem_rdata_i(mrd4), .xfer_cnt_o(xc4));

  obi_mem_bridge #(.ADDR_BASE(32'h0000_1000), .MEM_WORDS(16)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(reqB), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .gnt_o(gntB), .rvalid_o(rvB),
    .rdata_o(rdB), .err_o(errB), .mem_req_o(mreqB), .mem_we_o(mweB),
    .mem_be_o(mbeB), .mem_addr_o(maddrB), .mem_wdata_o(mwdB),
    .mem_rdata_i(mrdB), .xfer_cnt_o(xcB));

  function automatic logic [31:0] word(input logic [13:0] a);
    return (a == 14'd3) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous-read SRAM models: data one cycle after the strobe.
  always @(posedge clk) if (mreq0 && !mwe0) mrd0 <= word(maddr0);
  always @(posedge clk) if (mreq3 && !mwe3) mrd3 <= word(maddr3);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b1; req3 = 1'b1; req4 = 1'b1; reqB = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b0) begin
      failures++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0);
    end
    checks++;
    if (mreq0 !== 1'b0) begin
      failures++; $display("FAIL rst_mreq0 got=%b exp=0", mreq0);
    end
    tick; tick;
    checks++;
    if ({rv0, err0, rd0} !== 34'd0) begin
      failures++; $display("FAIL rst_resp got=%b/%b/%h exp=0", rv0, err0, rd0);
    end
    checks++;
    if (xc0 !== 32'd0 || xc4 !== 32'd0) begin
      failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0", xc0, xc4);
    end
    rst = 1'b0; req0 = 1'b0; req3 = 1'b0; req4 = 1'b0; reqB = 1'b0;
    tick;
  endtask

  task automatic test_read;
    req0 = 1'b1; addr = 32'h0C; we = 1'b0; be = 4'hF;
    #1;
    checks++;
    if ({gnt0, mreq0} !== 2'b11) begin
      failures++; $display("FAIL read_gnt got=%b%b exp=11", gnt0, mreq0);
    end
    checks++;
    if (maddr0 !== 14'd3) begin
      failures++; $display("FAIL read_maddr got=%0d exp=3", maddr0);
    end
    tick;
    req0 = 1'b0;
    checks++;
    if ({rv0, err0} !== 2'b10 || rd0 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_resp got=%b%b %h exp=10 deadbeef", rv0, err0, rd0);
    end
    tick;
    checks++;
    if (rv0 !== 1'b0 || rd0 !== 32'd0) begin
      failures++; $display("FAIL read_idle got=%b %h exp=0 0", rv0, rd0);
    end
  endtask

  task automatic test_write;
    req0 = 1'b1; addr = 32'h08; we = 1'b1; be = 4'b0011;
    wdata = 32'h1234_5678;
    #1;
    checks++;
    if ({mreq0, mwe0, mbe0} !== 6'b11_0011 || maddr0 !== 14'd2) begin
      failures++;
      $display("FAIL write_mem got=%b%b%b a=%0d exp=110011 a=2",
               mreq0, mwe0, mbe0, maddr0);
    end
    checks++;
    if (mwd0 !== 32'h1234_5678) begin
      failures++; $display("FAIL write_wdata got=%h exp=12345678", mwd0);
    end
    tick;
    req0 = 1'b0; we = 1'b0; be = 4'hF;
    checks++;
    if ({rv0, err0} !== 2'b10 || rd0 !== 32'd0) begin
      failures++; $display("FAIL write_resp got=%b%b %h exp=10 0", rv0, err0, rd0);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int pulses;
    pulses = 0;
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      req0 = 1'b1; addr = 32'(4 * i);
      #1;
      checks++;
      if (gnt0 !== 1'b1 || maddr0 !== 14'(i)) begin
        failures++; $display("FAIL b2b_gnt%0d got=%b a=%0d exp=1", i, gnt0, maddr0);
      end
      tick;
      if (rv0 === 1'b1) pulses++;
      checks++;
      if (rd0 !== word(14'(i))) begin
        failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, rd0, word(14'(i)));
      end
    end
    req0 = 1'b0;
    checks++;
    if (xc0 !== 32'd17 || pulses != 17) begin
      failures++; $display("FAIL b2b_count got=%0d/%0d exp=17", xc0, pulses);
    end
    tick;
    checks++;
    if (rv0 !== 1'b0) begin
      failures++; $display("FAIL b2b_tail got=%b exp=0", rv0);
    end
  endtask

  task automatic test_wait3;
    req3 = 1'b1; addr = 32'h10; we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (gnt3 !== (c == 3) || rv3 !== 1'b0) begin
        failures++; $display("FAIL w3_c%0d got=%b/%b exp=%b/0", c, gnt3, rv3, c == 3);
      end
      if (c == 3) begin
        checks++;
        if (mreq3 !== 1'b1 || maddr3 !== 14'd4) begin
          failures++; $display("FAIL w3_mem got=%b a=%0d exp=1 a=4", mreq3, maddr3);
        end
      end
      tick;
    end
    req3 = 1'b0;
    checks++;
    if (rv3 !== 1'b1 || rd3 !== 32'h1000_0004 || xc3 !== 32'd1) begin
      failures++; $display("FAIL w3_resp got=%b %h %0d exp=1 10000004 1", rv3, rd3, xc3);
    end
    tick;
  endtask

  task automatic test_drop3;
    addr = 32'h14;
    for (int c = 0; c < 7; c++) begin
      req3 = (c != 2);
      #1;
      checks++;
      if (gnt3 !== (c == 6) || rv3 !== 1'b0) begin
        failures++; $display("FAIL drop_c%0d got=%b/%b exp=%b/0", c, gnt3, rv3, c == 6);
      end
      tick;
    end
    req3 = 1'b0;
    checks++;
    if (rv3 !== 1'b1 || rd3 !== 32'h1000_0005 || xc3 !== 32'd2) begin
      failures++; $display("FAIL drop_resp got=%b %h %0d exp=1 10000005 2", rv3, rd3, xc3);
    end
    tick;
  endtask

  task automatic test_range;
    logic [31:0] ta [4];
    logic        tin [4];
    logic [3:0]  tw [4];
    ta = '{32'h1040, 32'h103C, 32'h0FFC, 32'h1000};
    tin = '{1'b0, 1'b1, 1'b0, 1'b1};
    tw = '{4'd0, 4'd15, 4'd0, 4'd0};
    for (int i = 0; i < 4; i++) begin
      reqB = 1'b1; addr = ta[i]; we = 1'b0;
      #1;
      checks++;
      if (gntB !== 1'b1 || mreqB !== tin[i] || (tin[i] && maddrB !== tw[i])) begin
        failures++;
        $display("FAIL range_req%0d got=%b%b a=%0d exp=1%b a=%0d",
                 i, gntB, mreqB, maddrB, tin[i], tw[i]);
      end
      tick;
      reqB = 1'b0;
      checks++;
      if (rvB !== 1'b1 || errB !== !tin[i] ||
          rdB !== (tin[i] ? 32'hCAFE_F00D : 32'd0)) begin
        failures++;
        $display("FAIL range_resp%0d got=%b%b %h exp=1%b", i, rvB, errB, rdB, !tin[i]);
      end
    end
    tick;
  endtask

  task automatic test_reset_wait;
    addr = 32'h0; we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req4 = 1'b1;
      rst = (c == 2);
      #1;
      checks++;
      if (gnt4 !== (c == 7) || rv4 !== 1'b0) begin
        failures++; $display("FAIL rw_c%0d got=%b/%b exp=%b/0", c, gnt4, rv4, c == 7);
      end
      tick;
    end
    req4 = 1'b0; rst = 1'b0;
    checks++;
    if (rv4 !== 1'b1 || rd4 !== 32'h5555_AAAA || xc4 !== 32'd1) begin
      failures++; $display("FAIL rw_resp got=%b %h %0d exp=1 5555aaaa 1", rv4, rd4, xc4);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_wait3;
    test_drop3;
    test_range;
    test_reset_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
